// File: rtl/fp_pkg.sv
// Shared FP32 definitions: field layout, bias, special encodings, flag
// indices and the converter FSM state type.
package fp_pkg;

   localparam int FP32_W   = 32;
   localparam int EXP_W    = 8;
   localparam int FRAC_W   = 23;
   localparam int MANT_W   = 24;
   localparam int SIGN_POS = 31;
   localparam int EXP_LSB  = 23;
   localparam int BIAS     = 127;

   localparam logic [31:0] FP32_QNAN    = 32'h7FC0_0000;
   localparam logic [31:0] FP32_POS_INF = 32'h7F80_0000;
   localparam logic [31:0] FP32_NEG_INF = 32'hFF80_0000;
   localparam logic [31:0] INT32_MAX    = 32'h7FFF_FFFF;
   localparam logic [31:0] INT32_MIN    = 32'h8000_0000;

   localparam int FLAG_INVALID  = 2;
   localparam int FLAG_OVERFLOW = 1;
   localparam int FLAG_INEXACT  = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2,
      DONE  = 2'd3
   } conv_state_e;

endpackage

// File: rtl/fp32_unpack.sv
// Combinational FP32 field decoder: sign, biased exponent, mantissa with
// hidden bit, unbiased exponent and special-value classification.
module fp32_unpack
   import fp_pkg::*;
(
   input  logic [FP32_W-1:0]       fp_i,
   output logic                    sign_o,
   output logic [EXP_W-1:0]        exp_o,
   output logic [MANT_W-1:0]       mant_o,
   output logic signed [EXP_W:0]   e_o,
   output logic                    is_nan_o,
   output logic                    is_inf_o,
   output logic                    is_zero_or_sub_o
);

   logic [FRAC_W-1:0] frac;

   // Split the word into fields and classify it.
   always_comb begin
      sign_o           = fp_i[SIGN_POS];
      exp_o            = fp_i[SIGN_POS-1:EXP_LSB];
      frac             = fp_i[FRAC_W-1:0];
      mant_o           = {(exp_o != '0), frac};
      e_o              = $signed({1'b0, exp_o}) - 9'sd127;
      is_nan_o         = (exp_o == '1) && (frac != '0);
      is_inf_o         = (exp_o == '1) && (frac == '0);
      is_zero_or_sub_o = (exp_o == '0);
   end

endmodule

// File: rtl/fp32_to_int32_conv.sv
// FP32 to INT32 converter: classify on accept, align with an iterative
// shifter (SHIFT_STEP bits per cycle), then round, negate and register.
// Build option: FP2INT_ROUND_NEAREST_EN selects round-half-to-even in FIN;
// without it the magnitude is truncated toward zero.
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high; the producer holds valid and data stable until that edge, and
// valid never depends on ready.
module fp32_to_int32_conv
   import fp_pkg::*;
#(
   parameter int SHIFT_STEP = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_data,
   output logic [2:0]         out_flags,
   output conv_state_e        state_o
);

   conv_state_e       state_q, state_d;
   logic              sign_q, sign_d;
   logic              left_q, left_d;
   logic [31:0]       mag_q, mag_d;
   logic              guard_q, guard_d;
   logic              sticky_q, sticky_d;
   logic [4:0]        n_q, n_d;
   logic [31:0]       data_q, data_d;
   logic [2:0]        flags_q, flags_d;

   logic              u_sign;
   logic [EXP_W-1:0]  u_exp;
   logic [MANT_W-1:0] u_mant;
   logic signed [8:0] u_e;
   logic              u_nan, u_inf, u_zs;

   logic signed [8:0] e_off;
   logic [8:0]        n_abs;
   logic [31:0]       rmag;
   logic              is_neg_2p31;

   fp32_unpack u_unpack (
      .fp_i             (in_data),
      .sign_o           (u_sign),
      .exp_o            (u_exp),
      .mant_o           (u_mant),
      .e_o              (u_e),
      .is_nan_o         (u_nan),
      .is_inf_o         (u_inf),
      .is_zero_or_sub_o (u_zs)
   );

   // Next-state, datapath step and result formation.
   always_comb begin
      state_d     = state_q;
      sign_d      = sign_q;
      left_d      = left_q;
      mag_d       = mag_q;
      guard_d     = guard_q;
      sticky_d    = sticky_q;
      n_d         = n_q;
      data_d      = data_q;
      flags_d     = flags_q;
      e_off       = u_e - 9'sd23;
      n_abs       = (e_off < 0) ? 9'(-e_off) : 9'(e_off);
      is_neg_2p31 = u_sign && (u_exp == 8'd158) && (in_data[FRAC_W-1:0] == '0);
      rmag        = mag_q;
`ifdef FP2INT_ROUND_NEAREST_EN
      if (guard_q && (sticky_q || mag_q[0])) rmag = mag_q + 32'd1;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d   = u_sign;
               mag_d    = {8'b0, u_mant};
               guard_d  = 1'b0;
               sticky_d = 1'b0;
               left_d   = 1'b0;
               n_d      = '0;
               flags_d  = '0;
               state_d  = DONE;
               if (u_nan) begin
                  data_d                = INT32_MAX;
                  flags_d[FLAG_INVALID] = 1'b1;
               end else if (u_inf) begin
                  data_d                 = u_sign ? INT32_MIN : INT32_MAX;
                  flags_d[FLAG_OVERFLOW] = 1'b1;
               end else if (is_neg_2p31) begin
                  data_d = INT32_MIN;
               end else if (u_e >= 9'sd31) begin
                  data_d                 = u_sign ? INT32_MIN : INT32_MAX;
                  flags_d[FLAG_OVERFLOW] = 1'b1;
               end else if (u_zs || (u_e <= -9'sd2)) begin
                  data_d                = '0;
                  flags_d[FLAG_INEXACT] = (in_data[30:0] != '0);
               end else begin
                  left_d  = (u_e > 9'sd23);
                  n_d     = n_abs[4:0];
                  state_d = (n_abs[4:0] != '0) ? SHIFT : FIN;
               end
            end
         end
         SHIFT: begin
            for (int i = 0; i < SHIFT_STEP; i++) begin
               if (n_d != '0) begin
                  if (left_q) begin
                     mag_d = {mag_d[30:0], 1'b0};
                  end else begin
                     sticky_d = sticky_d | guard_d;
                     guard_d  = mag_d[0];
                     mag_d    = {1'b0, mag_d[31:1]};
                  end
                  n_d = n_d - 5'd1;
               end
            end
            if (n_d == '0) state_d = FIN;
         end
         FIN: begin
            data_d  = sign_q ? (~rmag + 32'd1) : rmag;
            flags_d = {2'b00, guard_q | sticky_q};
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any in-flight word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         left_q   <= 1'b0;
         mag_q    <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
         n_q      <= '0;
         data_q   <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         left_q   <= left_d;
         mag_q    <= mag_d;
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
         n_q      <= n_d;
         data_q   <= data_d;
         flags_q  <= flags_d;
      end
   end

   assign in_ready  = (state_q == IDLE) & ~rst;
   assign out_valid = (state_q == DONE);
   assign out_data  = data_q;
   assign out_flags = flags_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_fp32_to_int32_conv.sv
// Directed bench for fp32_to_int32_conv: hand-computed vectors for special
// and normal cases, backpressure in DONE, and reset mid-conversion.
module tb_fp32_to_int32_conv;
   import fp_pkg::*;

   localparam int STEP = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [2:0]  out_flags;
   conv_state_e state_dbg;

   logic [31:0] exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   fp32_to_int32_conv #(.SHIFT_STEP(STEP)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_flags (out_flags),
      .state_o   (state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
      end
   endtask

   function automatic int lat_norm(input int n);
      return 2 + (n + STEP - 1) / STEP;
   endfunction

   // Drive one word, measure latency, check result, optionally stall DONE.
   task automatic convert(input string tag, input logic [31:0] din, input logic [31:0] dexp,
                          input logic [2:0] fexp, input int lat_exp, input int hold);
      int          w;
      int          lat;
      logic [31:0] got;
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check_eq({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      exp_q.push_back(dexp);
      in_valid = 1'b1;
      in_data  = din;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 200);
      check_eq({tag, "_latency"}, 32'(lat), 32'(lat_exp));
      got = exp_q.pop_front();
      check_eq({tag, "_data"}, out_data, got);
      check_eq({tag, "_flags"}, {29'b0, out_flags}, {29'b0, fexp});
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_data  = 32'h4000_0000 | 32'($urandom_range(0, 32'h3FFF_FFFF));
         @(negedge clk);
         check_eq({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
         check_eq({tag, "_hold_data"}, out_data, dexp);
         check_eq({tag, "_hold_flags"}, {29'b0, out_flags}, {29'b0, fexp});
         check_eq({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      check_eq({tag, "_post_in_ready"}, {31'b0, in_ready}, 32'd1);
      check_eq({tag, "_post_out_valid"}, {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] r15, r25, rm075;
      int          bad;
`ifdef FP2INT_ROUND_NEAREST_EN
      r15   = 32'd2;
      r25   = 32'd2;
      rm075 = 32'hFFFF_FFFF;
`else
      r15   = 32'd1;
      r25   = 32'd2;
      rm075 = 32'd0;
`endif
      // reset state
      repeat (2) @(negedge clk);
      check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
      check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("rst_out_data", out_data, 32'd0);
      check_eq("rst_out_flags", {29'b0, out_flags}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rel_in_ready", {31'b0, in_ready}, 32'd1);

      // normal conversions
      convert("exact_2p23", 32'h4B00_0000, 32'h0080_0000, 3'b000, lat_norm(0), 0);
      convert("neg_123_456", 32'hC2F6_E979, 32'hFFFF_FF85, 3'b001, lat_norm(17), 0);
      convert("one_half_1_5", 32'h3FC0_0000, r15, 3'b001, lat_norm(23), 0);
      convert("two_half_2_5", 32'h4020_0000, r25, 3'b001, lat_norm(22), 0);
      convert("e30_max", 32'h4EFF_FFFF, 32'h7FFF_FF80, 3'b000, lat_norm(7), 0);
      convert("half_0_5", 32'h3F00_0000, 32'd0, 3'b001, lat_norm(24), 0);
      convert("neg_0_75", 32'hBF40_0000, rm075, 3'b001, lat_norm(24), 0);

      // special cases
      convert("pos_2p31", 32'h4F00_0000, INT32_MAX, 3'b010, 1, 0);
      convert("neg_2p31", 32'hCF00_0000, INT32_MIN, 3'b000, 1, 0);
      convert("qnan", 32'h7FC0_0000, INT32_MAX, 3'b100, 1, 0);
      convert("neg_inf", FP32_NEG_INF, INT32_MIN, 3'b010, 1, 0);
      convert("min_sub", 32'h0000_0001, 32'd0, 3'b001, 1, 0);
      convert("quarter", 32'h3E80_0000, 32'd0, 3'b001, 1, 0);
      convert("pos_zero", 32'h0000_0000, 32'd0, 3'b000, 1, 0);

      // backpressure, then a second word straight after
      convert("stall", 32'h4228_0000, 32'h0000_002A, 3'b000, lat_norm(18), 5);
      convert("after_stall", 32'hC2F6_E979, 32'hFFFF_FF85, 3'b001, lat_norm(17), 0);

      // reset in the middle of SHIFT
      in_valid = 1'b1;
      in_data  = 32'h3FC0_0000;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check_eq("mid_busy_in_ready", {31'b0, in_ready}, 32'd0);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid || !in_ready) bad++;
      end
      check_eq("mid_rst_no_output", 32'(bad), 32'd0);
      convert("after_rst_42", 32'h4228_0000, 32'h0000_002A, 3'b000, lat_norm(18), 0);

      check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fp32_to_int32_conv.md
# fp32_to_int32_conv

Multi-cycle converter from IEEE-754 single precision to a 32-bit two's-complement integer. It sits downstream of the floating-point arithmetic unit and turns its packed float results back into integer values for the datapath. Each word is unpacked and classified, then aligned by an iterative shifter, then rounded, negated and saturated. Transfers use valid/ready handshakes on both sides, and only one conversion is in flight at a time.

## Interface
Parameters:
- SHIFT_STEP, default 1: maximum alignment bits shifted per cycle. Legal values are 1, 2, 4 and 8.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word; equals (state==IDLE) & ~rst.
- in_data  in  32  IEEE-754 single: {sign, exp[7:0], frac[22:0]}.
- out_valid  out  1  out_data and out_flags are valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  32  signed integer result.
- out_flags  out  3  {invalid, overflow, inexact}.

## Operation
- FSM states: IDLE, SHIFT, FIN, DONE.
- Accept: when in_valid & in_ready on a clock edge, register the decoded fields. mant = {exp!=0, frac} (24 bits). e = exp − 127.
- Classification at accept, with the next state:
  - exp==255, frac!=0 (NaN): out_data 0x7FFFFFFF, invalid=1, go to DONE.
  - exp==255, frac==0 (±Inf): saturate, overflow=1, go to DONE.
  - e ≥ 31, except exactly 0xCF000000: saturate, overflow=1, go to DONE.
  - 0xCF000000: out_data 0x80000000, no flags, go to DONE.
  - e ≤ −2, or exp==0 (zero/subnormal): out_data 0, inexact = (in_data[30:0]!=0), go to DONE.
  - Otherwise (−1 ≤ e ≤ 30): load mag = {8'b0, mant}, clear guard and sticky, set n = |e − 23| (0..24). Go to SHIFT if n > 0, else FIN.
- Saturation values: +0x7FFFFFFF for positive, 0x80000000 for negative.
- SHIFT, per cycle:
  - Shift by k = min(SHIFT_STEP, n), then n ← n − k.
  - Left when e > 23.
  - Right when e < 23. Bits shifted out update guard (the most recent bit out) and sticky (OR of all earlier bits out, including the previous guard).
  - Go to FIN when n reaches 0.
- FIN:
  - Apply rounding (see Configuration).
  - inexact = guard | sticky.
  - out_data = sign ? −mag : mag.
  - Register the result and go to DONE.
- DONE:
  - out_valid=1. out_data and out_flags are held stable.
  - On out_valid & out_ready, return to IDLE.
- Rounding never overflows: the maximum pre-round magnitude is below 2^31, and e=30 has no right shift.

## Timing
- Reset values: out_valid=0, out_data=0, out_flags=0, state=IDLE. in_ready=0 while rst is high and 1 from the first cycle after release.
- Accept edge is T.
  - Special cases: out_valid is high in cycle T+1.
  - Normal cases: out_valid is high in cycle T+2+ceil(n/SHIFT_STEP).
- in_ready is low from T+1 until the cycle after the output handshake.
- Minimum period between accepts equals latency + 1.
- in_valid is ignored outside IDLE. Upstream holds its word.
- out_ready held low keeps DONE indefinitely with the output unchanged.
- Asserting rst in any state aborts the conversion immediately. Nothing is output, and the in-flight word is lost.

## Configuration
- FP2INT_ROUND_NEAREST_EN:
  - Defined: FIN rounds the magnitude half-to-even. It increments mag when guard & (sticky | mag[0]).
  - Undefined: truncation toward zero.
- The inexact flag is identical in both builds.

## Structure
- Shared package fp_pkg holds:
  - FP32 field widths and positions.
  - BIAS=127.
  - Special encodings: QNaN, ±Inf, INT32_MAX=0x7FFFFFFF, INT32_MIN=0x80000000.
  - Flag bit indices: invalid=2, overflow=1, inexact=0.
  - The FSM state enum.
- One sub-module: fp32_unpack. It is combinational and produces sign, exp, mant, e, is_nan, is_inf and is_zero_or_sub. The future int-to-float block reuses it.

## Test plan
- 0x4B000000 (8388608): out_data 0x00800000, flags 0, n=0, out_valid at T+2.
- 0xC2F6E979 (−123.456), SHIFT_STEP=1: out_data 0xFFFFFF85, inexact=1, out_valid at T+19.
- 0x3FC00000 (1.5) and 0x40200000 (2.5): truncation gives 1 and 2; FP2INT_ROUND_NEAREST_EN gives 2 and 2. inexact=1 in all four results.
- 0x4F000000 gives 0x7FFFFFFF with overflow. 0xCF000000 gives 0x80000000 with flags 0. 0x7FC00000 gives 0x7FFFFFFF with invalid. 0x00000001 gives 0 with inexact. Each has out_valid at T+1.
- out_ready low for 5 cycles in DONE: output stable and in_ready=0 throughout. After the handshake, in_ready=1 in the next cycle and a second word is accepted.
- rst pulsed mid-SHIFT: out_valid=0 immediately, no result is emitted, in_ready=1 after release, and the next conversion of 0x42280000 (42) gives 0x0000002A.
